// File: rtl/song_sequencer_pkg.sv
// song_sequencer_pkg: shared note field widths, ROM word layout, state encoding
// and the song ROM contents with its per-song base table.
package song_sequencer_pkg;
    localparam int OCTAVE_BITS = 3;
    localparam int NOTE_BITS = 3;
    localparam int LENGTH_BITS = 3;
    localparam int FULL_NOTE_BITS = 28;
    localparam int LEN_LSB = 0;
    localparam int NOTE_LSB = LEN_LSB + LENGTH_BITS;
    localparam int OCT_LSB = NOTE_LSB + NOTE_BITS;
    localparam int END_BIT = OCT_LSB + OCTAVE_BITS;
    localparam int WORD_BITS = END_BIT + 1;
    localparam logic [NOTE_BITS-1:0] NOTE_REST = 3'd7;
    localparam int unsigned SONG_BASE [4] = '{0, 4, 8, 12};
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ARM, S_PLAY, S_GAP, S_PAUSE, S_DONE
    } state_t;
    // word = {end, octave, note, length}; song 2 is deliberately empty
    function automatic logic [WORD_BITS-1:0] rom_word(input int unsigned a);
        case (a)
            0: rom_word = 10'b0_100_000_010;
            1: rom_word = 10'b0_100_010_010;
            4: rom_word = 10'b0_011_111_001;
            5: rom_word = 10'b0_101_001_011;
            12: rom_word = 10'b0_010_011_100;
            13: rom_word = 10'b0_110_101_000;
            2, 6, 8, 14: rom_word = 10'b1_000_000_000;
            default: rom_word = '0;
        endcase
    endfunction
endpackage

// File: rtl/song_sequencer_rom.sv
// song_sequencer_rom: synchronous song ROM (1-cycle read latency) plus the
// combinational base-address lookup for the selected song.
module song_sequencer_rom import song_sequencer_pkg::*; #(
    parameter int SONG_COUNT = 4,
    parameter int ADDR_BITS = 8
) (
    input  logic                          clk,
    input  logic [ADDR_BITS-1:0]          addr,
    input  logic [$clog2(SONG_COUNT)-1:0] song_sel,
    output logic [WORD_BITS-1:0]          data,
    output logic [ADDR_BITS-1:0]          base
);
    always_ff @(posedge clk)
        data <= rom_word(32'(addr));
    always_comb
        base = ADDR_BITS'(SONG_BASE[song_sel]);
endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: walks a ROM song and presents one note at a time to the
// buzzer tone generator, with pause/resume, stop, looping and rests.
module song_sequencer import song_sequencer_pkg::*; #(
    parameter int SONG_COUNT = 4,
    parameter int ADDR_BITS = 8,
    parameter int GAP_CYCLES = 5_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          play,
    input  logic                          pause,
    input  logic                          stop,
    input  logic                          loop,
    input  logic [$clog2(SONG_COUNT)-1:0] song_sel,
    input  logic [FULL_NOTE_BITS-1:0]     full_note,
    input  logic                          snd_over,
    output logic                          snd_en,
    output logic [OCTAVE_BITS-1:0]        snd_octave,
    output logic [NOTE_BITS-1:0]          snd_note,
    output logic [LENGTH_BITS-1:0]        snd_length,
    output logic [FULL_NOTE_BITS-1:0]     snd_full_note,
    output logic                          mute,
    output logic                          playing,
    output logic                          paused,
    output logic [ADDR_BITS-1:0]          note_idx,
    output logic                          done
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    state_t state, nxt;
    logic [ADDR_BITS-1:0] addr, base_q, base_w;
    logic [WORD_BITS-1:0] word;
    logic [GW-1:0] gap_cnt;
    logic rest_q, resume_fetch;
    song_sequencer_rom #(.SONG_COUNT(SONG_COUNT), .ADDR_BITS(ADDR_BITS)) u_rom (
        .clk(clk), .addr(addr), .song_sel(song_sel), .data(word), .base(base_w)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else state <= nxt;
    // ARM exists so that the stale over from a disabled tone generator is never seen
    always_comb begin
        nxt = state;
        if (stop) nxt = S_IDLE;
        else case (state)
            S_IDLE, S_DONE: nxt = play ? S_FETCH : S_IDLE;
            S_FETCH: nxt = S_LOAD;
            S_LOAD: nxt = !word[END_BIT] ? S_ARM : loop ? S_FETCH : S_DONE;
            S_ARM: nxt = pause ? S_PAUSE : S_PLAY;
            S_PLAY: nxt = pause ? S_PAUSE : snd_over ? S_GAP : S_PLAY;
            S_GAP: nxt = pause ? S_PAUSE : gap_cnt == '0 ? S_FETCH : S_GAP;
            S_PAUSE: nxt = !pause ? S_PAUSE : resume_fetch ? S_FETCH : S_ARM;
            default: nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            addr <= '0;
            base_q <= '0;
            note_idx <= '0;
            gap_cnt <= '0;
            rest_q <= 1'b0;
            resume_fetch <= 1'b0;
            snd_octave <= '0;
            snd_note <= '0;
            snd_length <= '0;
            snd_full_note <= '0;
        end else begin
            if ((state == S_IDLE || state == S_DONE) && nxt == S_FETCH) begin
                addr <= base_w;
                base_q <= base_w;
                note_idx <= '0;
            end
            if (state == S_LOAD && nxt == S_FETCH) begin
                addr <= base_q;
                note_idx <= '0;
            end
            if (state == S_LOAD && nxt == S_ARM) begin
                rest_q <= word[NOTE_LSB +: NOTE_BITS] == NOTE_REST;
                snd_octave <= word[OCT_LSB +: OCTAVE_BITS];
                snd_note <= word[NOTE_LSB +: NOTE_BITS] == NOTE_REST ? '0 : word[NOTE_LSB +: NOTE_BITS];
                snd_length <= word[LEN_LSB +: LENGTH_BITS];
                snd_full_note <= full_note;
            end
            if (state == S_PLAY && nxt == S_GAP) begin
                addr <= addr + 1'b1;
                note_idx <= note_idx + 1'b1;
                gap_cnt <= GAP_LAST;
            end
            if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
            if (state != S_PAUSE && nxt == S_PAUSE) resume_fetch <= state == S_GAP;
        end
    always_comb begin
        snd_en = state == S_ARM || state == S_PLAY;
        mute = snd_en && rest_q;
        playing = state inside {S_FETCH, S_LOAD, S_ARM, S_PLAY, S_GAP};
        paused = state == S_PAUSE;
        done = state == S_DONE;
    end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed bench with a small Sound model that raises over
// OVER_LEN cycles after enable and a bench-controlled stale over while idle.
module tb_song_sequencer;
    import song_sequencer_pkg::*;
    localparam int GAP = 4;
    localparam int OVER_LEN = 20;
    logic clk = 0, rst = 1, play = 0, pause = 0, stop = 0, loop = 0, stale = 0;
    logic [1:0] song_sel = 0;
    logic [FULL_NOTE_BITS-1:0] full_note = 0;
    logic snd_over, snd_en, mute, playing, paused, done;
    logic [OCTAVE_BITS-1:0] snd_octave;
    logic [NOTE_BITS-1:0] snd_note;
    logic [LENGTH_BITS-1:0] snd_length;
    logic [FULL_NOTE_BITS-1:0] snd_full_note;
    logic [7:0] note_idx;
    int en_cnt, en_total, done_total, total, bad;
    song_sequencer #(.SONG_COUNT(4), .ADDR_BITS(8), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop), .loop(loop),
        .song_sel(song_sel), .full_note(full_note), .snd_over(snd_over), .snd_en(snd_en),
        .snd_octave(snd_octave), .snd_note(snd_note), .snd_length(snd_length),
        .snd_full_note(snd_full_note), .mute(mute), .playing(playing), .paused(paused),
        .note_idx(note_idx), .done(done)
    );
    always #5 clk = ~clk;
    assign snd_over = (en_cnt == 0) ? stale : (en_cnt >= OVER_LEN);
    always @(posedge clk or posedge rst)
        if (rst) en_cnt <= 0;
        else en_cnt <= snd_en ? en_cnt + 1 : 0;
    always @(posedge clk) begin
        en_total <= en_total + int'(snd_en);
        done_total <= done_total + int'(done);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic start(input logic [1:0] s);
        song_sel = s;
        play = 1;
        step(1);
        play = 0;
    endtask
    task automatic halt();
        stop = 1;
        step(1);
        stop = 0;
    endtask
    task automatic run_while(input logic lvl, output int n);
        n = 0;
        while (snd_en === lvl && n < 200) begin
            step(1);
            n++;
        end
    endtask
    initial begin
        int n, d0, e0;
        step(2);
        chk("rst_ctl", 32'({snd_en, mute, playing, paused, done}), 0);
        chk("rst_fields", 32'({snd_octave, snd_note, snd_length}), 0);
        chk("rst_idx", 32'(note_idx), 0);
        rst = 0;
        full_note = 1234;
        d0 = done_total;
        start(0);
        chk("t1_fetch", 32'({playing, snd_en}), 32'b10);
        step(1);
        chk("t1_load_en", 32'(snd_en), 0);
        step(1);
        chk("t1_arm_en", 32'(snd_en), 1);
        chk("t1_note0", 32'({snd_octave, snd_note, snd_length}), 32'({3'd4, 3'd0, 3'd2}));
        chk("t1_tempo", 32'(snd_full_note), 1234);
        run_while(1, n);
        chk("t1_len0", n, OVER_LEN + 1);
        run_while(0, n);
        chk("t1_gap", n, GAP + 2);
        chk("t1_note1", 32'({snd_octave, snd_note, snd_length}), 32'({3'd4, 3'd2, 3'd2}));
        chk("t1_idx1", 32'(note_idx), 1);
        run_while(1, n);
        chk("t1_len1", n, OVER_LEN + 1);
        step(GAP + 2);
        chk("t1_done", 32'({done, playing}), 32'b10);
        step(1);
        chk("t1_idle", 32'({done, playing}), 0);
        chk("t1_done_cnt", done_total - d0, 1);
        stale = 1;
        start(0);
        step(2);
        chk("t2_arm", 32'(snd_en), 1);
        step(3);
        chk("t2_hold", 32'({snd_en, note_idx}), 32'({1'b1, 8'd0}));
        halt();
        stale = 0;
        chk("t2_stop", 32'({playing, snd_en}), 0);
        start(1);
        step(2);
        chk("t3_rest_ctl", 32'({mute, snd_en}), 32'b11);
        chk("t3_rest_fields", 32'({snd_octave, snd_note, snd_length}), 32'({3'd3, 3'd0, 3'd1}));
        run_while(1, n);
        chk("t3_rest_len", n, OVER_LEN + 1);
        run_while(0, n);
        chk("t3_gap", n, GAP + 2);
        chk("t3_note1", 32'({mute, snd_octave, snd_note, snd_length, note_idx}),
            32'({1'b0, 3'd5, 3'd1, 3'd3, 8'd1}));
        halt();
        start(0);
        step(7);
        pause = 1;
        step(1);
        pause = 0;
        chk("t4_paused", 32'({snd_en, paused, playing}), 32'b010);
        step(3);
        chk("t4_still", 32'({snd_en, paused}), 32'b01);
        pause = 1;
        step(1);
        pause = 0;
        chk("t4_resume", 32'({snd_en, paused, note_idx}), 32'({2'b10, 8'd0}));
        chk("t4_fields", 32'({snd_octave, snd_note, snd_length}), 32'({3'd4, 3'd0, 3'd2}));
        run_while(1, n);
        chk("t4_restart", n, OVER_LEN + 1);
        halt();
        loop = 1;
        d0 = done_total;
        start(3);
        step(2);
        chk("t5_note0", 32'({snd_octave, snd_note, snd_length}), 32'({3'd2, 3'd3, 3'd4}));
        run_while(1, n);
        run_while(0, n);
        chk("t5_note1", 32'({snd_octave, snd_note, snd_length, note_idx}),
            32'({3'd6, 3'd5, 3'd0, 8'd1}));
        run_while(1, n);
        run_while(0, n);
        chk("t5_wrap_gap", n, GAP + 4);
        chk("t5_wrap", 32'({snd_octave, snd_note, snd_length, note_idx}),
            32'({3'd2, 3'd3, 3'd4, 8'd0}));
        run_while(1, n);
        halt();
        loop = 0;
        chk("t5_stop", 32'({playing, snd_en}), 0);
        step(10);
        chk("t5_quiet", 32'({playing, snd_en}), 0);
        chk("t5_no_done", done_total - d0, 0);
        start(0);
        step(7);
        chk("t6_pre", 32'(snd_en), 1);
        #2 rst = 1;
        #1;
        chk("t6_ctl", 32'({snd_en, mute, playing, paused, done}), 0);
        chk("t6_fields", 32'({snd_octave, snd_note, snd_length, note_idx}), 0);
        chk("t6_tempo", 32'(snd_full_note), 0);
        step(1);
        rst = 0;
        d0 = done_total;
        e0 = en_total;
        start(2);
        chk("t7_fetch", 32'({done, playing}), 32'b01);
        step(1);
        chk("t7_load", 32'(done), 0);
        step(1);
        chk("t7_done", 32'({done, playing}), 32'b10);
        step(1);
        chk("t7_idle", 32'(done), 0);
        chk("t7_no_en", en_total - e0, 0);
        chk("t7_done_cnt", done_total - d0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
